// File: rtl/instr_fetch_decode.sv
// Program-memory fetch/decode front end; the optional uninitialised-read check is built in with IFD_UNINIT_CHECK_EN.
// Latency: start -> out_valid in 3 cycles; each instruction takes 4+ cycles (fetch, decode, issue, retire).
// Backpressure: out_valid and all fields hold until out_ready; the next fetch waits for retire.
module instr_fetch_decode #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int IW    = 40
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [IW-1:0] load_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  output logic          out_valid,
  input  logic          out_ready,
  input  logic          retire,
  input  logic          wb_en,
  input  logic          wb_en2,
  input  logic [7:0]    wb_addr,
  input  logic [7:0]    wb_addr2,
  output logic [AW-1:0] pc_out,
  output logic [5:0]    opcode,
  output logic [1:0]    mode,
  output logic [7:0]    op1_addr,
  output logic [7:0]    op2_addr,
  output logic [15:0]   op1_imm,
  output logic [15:0]   op2_imm,
  output logic          busy,
  output logic          done,
  output logic          err_uninit,
  output logic [7:0]    err_reg
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, ISSUE, WAIT_RET, DONE, ERROR} state_t;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [1:0]  mode;
    logic [7:0]  op1_addr;
    logic [7:0]  op2_addr;
    logic [15:0] op1_imm;
    logic [15:0] op2_imm;
  } dec_t;

  state_t        state;
  logic [IW-1:0] mem [DEPTH];
  logic [IW-1:0] rd_dat;
  logic [AW-1:0] pc;
  logic [AW:0]   len;
  dec_t          dec_nxt;
  dec_t          dec_q;
  logic          idle_st;
  logic          chk_fail;
  logic [7:0]    chk_reg;

  assign idle_st = (state == IDLE) || (state == DONE) || (state == ERROR);
  assign busy    = !idle_st;

  // Loads are only accepted while nothing is executing.
  always_ff @(posedge clk) begin
    if (load_en && idle_st) mem[load_addr] <= load_data;
    if (state == FETCH) rd_dat <= mem[pc];
  end

  always_comb begin
    dec_nxt        = '0;
    dec_nxt.opcode = rd_dat[39:34];
    dec_nxt.mode   = rd_dat[33:32];
    case (rd_dat[33:32])
      2'b00: begin
        dec_nxt.op1_addr = rd_dat[31:24];
        dec_nxt.op2_addr = rd_dat[23:16];
      end
      2'b01: begin
        dec_nxt.op1_addr = rd_dat[31:24];
        dec_nxt.op2_imm  = rd_dat[23:8];
      end
      2'b10: begin
        dec_nxt.op1_imm  = rd_dat[31:16];
        dec_nxt.op2_addr = rd_dat[15:8];
      end
      default: begin
        dec_nxt.op1_imm  = rd_dat[31:16];
        dec_nxt.op2_imm  = rd_dat[15:0];
      end
    endcase
  end

`ifdef IFD_UNINIT_CHECK_EN
  logic [255:0] init_map;
  logic [255:0] init_vis;

  // Same-cycle writebacks count as initialised for the check.
  always_comb begin
    init_vis = init_map;
    if (wb_en)  init_vis[wb_addr]  = 1'b1;
    if (wb_en2) init_vis[wb_addr2] = 1'b1;
  end

  always_comb begin
    chk_fail = 1'b0;
    chk_reg  = '0;
    case (dec_nxt.mode)
      2'b00: begin
        if (!init_vis[dec_nxt.op1_addr]) begin
          chk_fail = 1'b1;
          chk_reg  = dec_nxt.op1_addr;
        end else if (!init_vis[dec_nxt.op2_addr]) begin
          chk_fail = 1'b1;
          chk_reg  = dec_nxt.op2_addr;
        end
      end
      2'b10: begin
        if (!init_vis[dec_nxt.op2_addr]) begin
          chk_fail = 1'b1;
          chk_reg  = dec_nxt.op2_addr;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) init_map <= '0;
    else if (idle_st && start) init_map <= '0;
    else init_map <= init_vis;
  end
`else
  logic unused_wb;
  assign unused_wb = ^{wb_en, wb_en2, wb_addr, wb_addr2};
  assign chk_fail  = 1'b0;
  assign chk_reg   = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= '0;
      len        <= '0;
      dec_q      <= '0;
      out_valid  <= 1'b0;
      done       <= 1'b0;
      err_uninit <= 1'b0;
      err_reg    <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            len        <= prog_len;
            pc         <= '0;
            done       <= (prog_len == '0);
            err_uninit <= 1'b0;
            err_reg    <= '0;
            state      <= (prog_len == '0) ? DONE : FETCH;
          end
        end
        FETCH: state <= DECODE;
        DECODE: begin
          dec_q <= dec_nxt;
          if (chk_fail) begin
            state      <= ERROR;
            err_uninit <= 1'b1;
            err_reg    <= chk_reg;
          end else begin
            state     <= ISSUE;
            out_valid <= 1'b1;
          end
        end
        ISSUE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= WAIT_RET;
          end
        end
        WAIT_RET: begin
          if (retire) begin
            if ({1'b0, pc} == len - 1'b1) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              pc    <= pc + 1'b1;
              state <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pc_out   = pc;
  assign opcode   = dec_q.opcode;
  assign mode     = dec_q.mode;
  assign op1_addr = dec_q.op1_addr;
  assign op2_addr = dec_q.op2_addr;
  assign op1_imm  = dec_q.op1_imm;
  assign op2_imm  = dec_q.op2_imm;
endmodule

// File: tb/tb_instr_fetch_decode.sv
// Bench for instr_fetch_decode: program-level model, per-cycle field compare, directed programs.
module tb_instr_fetch_decode;
`ifdef IFD_UNINIT_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1, load_en = 1'b0, start = 1'b0;
  logic        out_ready = 1'b1, retire = 1'b0, wb_en = 1'b0, wb_en2 = 1'b0;
  logic [7:0]  load_addr = '0, wb_addr = '0, wb_addr2 = '0;
  logic [39:0] load_data = '0;
  logic [8:0]  prog_len = '0;
  logic        out_valid, busy, done, err_uninit;
  logic [7:0]  pc_out, op1_addr, op2_addr, err_reg;
  logic [5:0]  opcode;
  logic [1:0]  mode;
  logic [15:0] op1_imm, op2_imm;

  instr_fetch_decode dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .prog_len(prog_len), .start(start), .out_valid(out_valid), .out_ready(out_ready),
    .retire(retire), .wb_en(wb_en), .wb_en2(wb_en2), .wb_addr(wb_addr), .wb_addr2(wb_addr2),
    .pc_out(pc_out), .opcode(opcode), .mode(mode), .op1_addr(op1_addr), .op2_addr(op2_addr),
    .op1_imm(op1_imm), .op2_imm(op2_imm), .busy(busy), .done(done),
    .err_uninit(err_uninit), .err_reg(err_reg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  pc;
    logic [5:0]  opcode;
    logic [1:0]  mode;
    logic [7:0]  a1;
    logic [7:0]  a2;
    logic [15:0] i1;
    logic [15:0] i2;
  } obs_t;

  obs_t        dut_obs, first_obs, last_obs;
  obs_t        exp_q[$];
  logic [39:0] mem_m [256];
  int          dst_m [256];
  int          n_exp, n_pass, n_total, last_hs;
  bit          exp_err;
  logic [7:0]  exp_reg;

  assign dut_obs = {pc_out, opcode, mode, op1_addr, op2_addr, op1_imm, op2_imm};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic obs_t fields_of(input int pc, input logic [39:0] w);
    obs_t e;
    e        = '0;
    e.pc     = 8'(pc);
    e.opcode = w[39:34];
    e.mode   = w[33:32];
    if (!e.mode[1]) e.a1 = w[31:24];
    else            e.i1 = w[31:16];
    case (e.mode)
      2'd0: e.a2 = w[23:16];
      2'd1: e.i2 = w[23:8];
      2'd2: e.a2 = w[15:8];
      default: e.i2 = w[15:0];
    endcase
    return e;
  endfunction

  // Walk the program in order; registers become initialised when their writer retires.
  task automatic build(input int len, input bit pre);
    bit   init [256];
    obs_t e;
    foreach (init[i]) init[i] = 1'b0;
    if (pre) begin init[2] = 1'b1; init[3] = 1'b1; end
    exp_q.delete();
    n_exp = 0; exp_err = 1'b0; exp_reg = '0;
    for (int i = 0; i < len; i++) begin
      e = fields_of(i, mem_m[i]);
      if (CHK_EN && e.mode == 2'd0 && !init[e.a1]) begin exp_err = 1'b1; exp_reg = e.a1; end
      else if (CHK_EN && (e.mode == 2'd0 || e.mode == 2'd2) && !init[e.a2]) begin
        exp_err = 1'b1; exp_reg = e.a2;
      end
      if (exp_err) break;
      exp_q.push_back(e);
      n_exp++;
      if (dst_m[i] >= 0) init[dst_m[i]] = 1'b1;
    end
  endtask

  task automatic load(input int a, input logic [39:0] w, input int d);
    @(posedge clk); #1;
    load_en = 1'b1; load_addr = 8'(a); load_data = w;
    @(posedge clk); #1;
    load_en = 1'b0;
    mem_m[a] = w; dst_m[a] = d;
  endtask

  task automatic run(input int len, input int stall, input bit pre, input bit co_load,
                     input logic [39:0] co_word, input bit busy_load);
    int first_v = -1, acc_it = -1, end_it = -1, hs = 0, stall_left = stall;
    bit acc_last = 1'b0;
    if (co_load) begin mem_m[0] = co_word; dst_m[0] = -1; end
    build(len, pre);
    @(posedge clk); #1;
    start = 1'b1; prog_len = 9'(len);
    if (co_load) begin load_en = 1'b1; load_addr = '0; load_data = co_word; end
    for (int it = 1; it <= 3000; it++) begin
      @(posedge clk); #1;
      start = 1'b0; load_en = 1'b0; retire = 1'b0; wb_en = 1'b0; wb_en2 = 1'b0;
      if (acc_last) begin
        retire = 1'b1; acc_last = 1'b0;
        if (dst_m[hs-1] >= 0) begin wb_en = 1'b1; wb_addr = 8'(dst_m[hs-1]); end
      end
      if (pre && it == 2) begin wb_en = 1'b1; wb_addr = 8'd2; wb_en2 = 1'b1; wb_addr2 = 8'd3; end
      if (busy_load && out_valid && stall_left > 0) begin
        load_en = 1'b1; load_addr = '0; load_data = 40'hFF_FFFF_FFFF;
      end
      out_ready = (stall_left == 0);
      if (out_valid && first_v < 0) begin first_v = it; first_obs = dut_obs; end
      if (out_valid && !out_ready) stall_left--;
      if (out_valid && out_ready) begin
        acc_last = 1'b1; hs++; last_obs = dut_obs;
        if (acc_it < 0) acc_it = it;
      end
      if (done || err_uninit) begin end_it = it; break; end
    end
    retire = 1'b0; wb_en = 1'b0; wb_en2 = 1'b0; load_en = 1'b0; out_ready = 1'b1;
    last_hs = hs;
    chk("terminated", 64'(end_it >= 0), 64'(1));
    chk("handshakes", 64'(hs), 64'(n_exp));
    chk("done", 64'(done), 64'(!exp_err));
    chk("err_uninit", 64'(err_uninit), 64'(exp_err));
    chk("err_reg", 64'(err_reg), 64'(exp_reg));
    chk("busy_end", 64'(busy), 64'(0));
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    if (n_exp > 0) begin
      chk("first_valid_cycle", 64'(first_v), 64'(3));
      chk("accept_cycle", 64'(acc_it), 64'(first_v + stall));
    end else begin
      chk("no_valid", 64'(first_v), 64'(-1));
    end
    if (len == 0) chk("done_latency", 64'(end_it), 64'(1));
    if (len > 0 && n_exp == 0 && exp_err) chk("err_latency", 64'(end_it), 64'(3));
  endtask

  // Every presented instruction must match the model's next expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      chk("busy_while_valid", 64'(busy), 64'(1));
      if (exp_q.size() == 0) chk("spurious_valid", 64'(out_valid), 64'(0));
      else begin
        chk("fields", 64'(dut_obs), 64'(exp_q[0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    bit found;
    n_pass = 0; n_total = 0;
    foreach (dst_m[i]) begin dst_m[i] = -1; mem_m[i] = '0; end
    repeat (3) @(posedge clk); #1;
    chk("reset_ctl", 64'({out_valid, busy, done, err_uninit, err_reg}), 64'(0));
    chk("reset_fields", 64'(dut_obs), 64'(0));
    rst = 1'b0;

    // MOV R1 #5
    load(0, 40'h7D01000500, 1);
    run(1, 0, 0, 0, '0, 0);
    chk("t1_literal", 64'(first_obs), {8'd0, 6'h1F, 2'b01, 8'd1, 8'd0, 16'd0, 16'd5});

    // ADD R2 R3 cold
    load(0, 40'h0402030000, 2);
    run(1, 0, 0, 0, '0, 0);
    chk("t2_err_uninit", 64'(err_uninit), 64'(CHK_EN));
    chk("t2_err_reg", 64'(err_reg), CHK_EN ? 64'd2 : 64'd0);

    // MOV R2, MOV R3, ADD R2 R3
    load(0, 40'h7D02000A00, 2);
    load(1, 40'h7D03000700, 3);
    load(2, 40'h0402030000, 2);
    run(3, 0, 0, 0, '0, 0);
    chk("t3_handshakes", 64'(last_hs), 64'd3);
    chk("t3_last_pc", 64'(last_obs.pc), 64'd2);

    // 5-cycle stall with an ignored load, then rerun to confirm memory untouched
    run(3, 5, 0, 0, '0, 1);
    run(3, 0, 0, 0, '0, 0);
    chk("t4_mem_kept", 64'(first_obs.i2), 64'h000A);

    // same-cycle writeback bypass on both ports
    load(0, 40'h0402030000, -1);
    run(1, 0, 1, 0, '0, 0);
    chk("t5_bypass_issue", 64'(last_hs), 64'd1);

    // modes 10/11, then a mode-10 uninit read of R9
    load(0, 40'h7D07000100, 7);
    load(1, 40'h0A123407FF, -1);
    load(2, 40'h0FABCD5678, -1);
    load(3, 40'h0A000009AA, -1);
    run(4, 0, 0, 0, '0, 0);
    chk("t6_err_reg", 64'(err_reg), CHK_EN ? 64'd9 : 64'd0);

    // mode 00: both uninit reports op1; op1 ok reports op2
    load(0, 40'h0405060000, -1);
    run(1, 0, 0, 0, '0, 0);
    chk("t7a_err_reg", 64'(err_reg), CHK_EN ? 64'd5 : 64'd0);
    load(0, 40'h7D01000500, 1);
    load(1, 40'h0401090000, -1);
    run(2, 0, 0, 0, '0, 0);
    chk("t7b_err_reg", 64'(err_reg), CHK_EN ? 64'd9 : 64'd0);

    // load coinciding with start is written and start is taken
    run(1, 0, 0, 1, 40'h0FABCD5678, 0);
    chk("t8_co_load", 64'(first_obs), {8'd0, 6'h03, 2'b11, 8'd0, 8'd0, 16'hABCD, 16'h5678});

    // reset while waiting for retire, then a zero-length program
    load(0, 40'h7D01000500, 1);
    load(1, 40'h7D02000A00, 2);
    build(2, 0);
    @(posedge clk); #1;
    start = 1'b1; prog_len = 9'd2;
    found = 1'b0;
    for (int it = 0; it < 10; it++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (out_valid) begin found = 1'b1; break; end
    end
    chk("t9_reached_issue", 64'(found), 64'(1));
    @(posedge clk); #1;
    chk("t9_in_wait_ret", 64'({busy, out_valid}), 64'(2'b10));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    chk("t9_reset_ctl", 64'({out_valid, busy, done, err_uninit, err_reg}), 64'(0));
    chk("t9_reset_fields", 64'(dut_obs), 64'(0));
    rst = 1'b0;
    run(0, 0, 0, 0, '0, 0);

    // full 256-instruction program, PC must not wrap
    for (int i = 0; i < 256; i++)
      load(i, {6'(i % 64), 2'b01, 8'(i), 16'(i * 7), 8'(255 - i)}, -1);
    run(256, 0, 0, 0, '0, 0);
    chk("t10_count", 64'(last_hs), 64'd256);
    chk("t10_last_pc", 64'(last_obs.pc), 64'd255);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
